uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Asynchronous UART transmitter with a small input FIFO and an internal baud divider. Bytes are written over a valid/ready handshake and serialised on `tx` as 8N1 frames (optionally 8N2), LSB first, with no idle gap between buffered bytes. It is the transmit partner of the 8x-oversampling UART receiver and drives the board's serial TX pin.

## Interface
- `clk_freq`, default 12000000: clock frequency in Hz.
- `baud`, default 115200: line rate. `DIV = (clk_freq + baud/2) / baud`, integer rounding. Default `DIV` is 104. `DIV` must be ≥ 2.
- `fifo_depth`, default 4: FIFO entries. Must be a power of 2 and ≥ 2.
- `stop_bits`, default 1: number of stop bits, 1 or 2.

- `clk`  in  1: the single clock; all state changes on the rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `tx_valid`  in  1: `tx_data` is offered.
- `tx_data`  in  8: byte to send.
- `tx_ready`  out  1: FIFO can accept a byte. Combinational, equal to `!full`.
- `tx`  out  1: serial line. Registered. Idle level is high.
- `tx_busy`  out  1: high when the FSM is not IDLE or the FIFO is non-empty. Registered.
- `tx_done`  out  1: one-cycle pulse when the last stop bit of a frame ends.

## Operation
- **Reset (async):** FIFO is emptied, FSM goes to IDLE, baud counter is cleared.
  - Reset values: `tx`=1, `tx_busy`=0, `tx_done`=0, `tx_ready`=1.
  - A reset mid-frame drives `tx` high immediately and discards the frame in flight and all queued bytes.
- **FIFO:**
  - Push happens when `tx_valid && tx_ready` at a rising edge.
  - Pop is performed only by the FSM.
  - Occupancy counter width is log2(`fifo_depth`)+1. Read and write pointers wrap modulo `fifo_depth`.
  - When full, `tx_ready`=0 and the push is ignored, even if a pop occurs in the same cycle.
  - Simultaneous push and pop on a non-full FIFO leaves the count unchanged.
  - There is no bypass: a byte written into an empty FIFO is popped no earlier than the next edge.
- **Baud counter:**
  - Counts 0..`DIV`-1 and is reset to 0 on every entry into START.
  - A `bit_end` strobe fires when the count is `DIV`-1.
  - Every bit lasts exactly `DIV` clocks.
- **FSM states:**
  - IDLE: `tx`=1. If the FIFO is non-empty, pop into an 8-bit shift register and go to START.
  - START: `tx`=0. On `bit_end`, go to DATA with bit index 0.
  - DATA: `tx`=`shift[0]`. On `bit_end`, shift right and increment the bit index. Go to STOP after index 7.
  - STOP: `tx`=1 for `stop_bits` bit times. At the final `bit_end`:
    - pulse `tx_done`;
    - if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no extra idle cycle);
    - otherwise go to IDLE.
  - Any illegal state encoding goes to IDLE with `tx`=1.
- **Input handling:** `tx_data` is captured only at push. Changes on `tx_data` while `tx_valid`=0 have no effect.

## Timing
- **Accept to line:** byte accepted at edge E0 into an empty FIFO with the FSM in IDLE. The FSM pops at E1, so `tx` falls after E1, i.e. one clock after acceptance.
- **Frame length:** (9 + `stop_bits`) × `DIV` clocks. With defaults this is 1040 clocks.
- **`tx_done`:** high for exactly the one cycle following the edge that ends the last stop bit. On a back-to-back transfer, `tx` falls at that same edge.
- **`tx_ready` recovery:** deasserts combinationally in the cycle the count reaches `fifo_depth`. It reasserts the cycle after the pop edge.
- **`tx_busy`:**
  - rises one clock after the first accepted push;
  - falls one clock after the FSM returns to IDLE with the FIFO empty.

## Test plan
1. **Reset state:** hold `rst` high, then release. Required: `tx`=1, `tx_busy`=0, `tx_ready`=1; `tx` stays high for 2000 clocks with `tx_valid`=0.
2. **Single byte:** push 0x55 with defaults. Required:
   - `tx` low 104 clocks, then 1,0,1,0,1,0,1,0, each 104 clocks, then high;
   - `tx_done` pulses once, 1040 clocks after `tx` falls;
   - `tx_busy` drops the next clock.
3. **Burst:** hold `tx_valid`=1 with bytes 0x01..0x06. Required:
   - `tx_ready` drops after 5 accepts (4 queued plus 1 popped on the first IDLE pop);
   - the six frames appear contiguously, 6240 clocks total, with no idle cycle between them;
   - the decoded data order is 0x01..0x06.
4. **Full-FIFO simultaneous push and pop:** with the FIFO full and a pop at the same edge as `tx_valid`=1, the push is not accepted and that byte never appears on `tx`.
5. **Reset mid-frame:** assert `rst` during data bit 3 of 0xA3 with 2 bytes queued. Required:
   - `tx`=1 immediately (asynchronously);
   - after release, no further frames are sent and `tx_busy`=0.
6. **Two stop bits:** with `stop_bits`=2 and `baud`=1000000 (`DIV`=12), push 0xFF, 0x00 back-to-back. Required:
   - first frame is 132 clocks, with stop high for 24 clocks;
   - second start bit begins at clock 132.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1 or 8N2, LSB first) fed by a small byte FIFO.
// Queued bytes leave back to back: the stop bit's last edge starts the next frame.
module uart_tx_fifo #(
  parameter int unsigned clk_freq   = 12000000,
  parameter int unsigned baud       = 115200,
  parameter int unsigned fifo_depth = 4,
  parameter int unsigned stop_bits  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);
  localparam int unsigned DIV = (clk_freq + baud / 2) / baud;
  localparam int unsigned AW  = $clog2(fifo_depth);
  localparam int unsigned CW  = $clog2(DIV);

  localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
  localparam logic [AW:0]   COUNT_FULL = (AW + 1)'(fifo_depth);
  localparam logic          STOP_LAST  = (stop_bits == 2) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic [7:0]    mem_r [fifo_depth];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;

  state_t        state_r;
  state_t        state_next_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_next_s;
  logic [2:0]    bit_idx_r;
  logic [2:0]    bit_idx_next_s;
  logic          stop_idx_r;
  logic          stop_idx_next_s;
  logic [7:0]    shift_r;
  logic [7:0]    shift_next_s;
  logic          bit_end_s;
  logic          done_next_s;
  logic          tx_next_s;
  logic          tx_r;
  logic          busy_r;
  logic          done_r;

  // A full FIFO refuses the push even if the FSM pops on the same edge.
  assign full_s    = (count_r == COUNT_FULL);
  assign empty_s   = (count_r == {(AW + 1){1'b0}});
  assign push_s    = tx_valid && !full_s;
  assign tx_ready  = !full_s;
  assign bit_end_s = (cnt_r == CNT_LAST);

  assign tx      = tx_r;
  assign tx_busy = busy_r;
  assign tx_done = done_r;

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= tx_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW + 1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Frame sequencing: next state, baud count, shift register and pops
  always_comb begin
    state_next_s    = state_r;
    cnt_next_s      = cnt_r;
    bit_idx_next_s  = bit_idx_r;
    stop_idx_next_s = stop_idx_r;
    shift_next_s    = shift_r;
    pop_s           = 1'b0;
    done_next_s     = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_next_s = {CW{1'b0}};
        if (!empty_s) begin
          pop_s        = 1'b1;
          shift_next_s = mem_r[rd_ptr_r];
          state_next_s = START;
        end else begin
          state_next_s = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          cnt_next_s     = {CW{1'b0}};
          bit_idx_next_s = 3'd0;
          state_next_s   = DATA;
        end else begin
          cnt_next_s = cnt_r + 1'b1;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          cnt_next_s     = {CW{1'b0}};
          shift_next_s   = {1'b0, shift_r[7:1]};
          bit_idx_next_s = bit_idx_r + 3'd1;
          if (bit_idx_r == 3'd7) begin
            stop_idx_next_s = 1'b0;
            state_next_s    = STOP;
          end else begin
            state_next_s = DATA;
          end
        end else begin
          cnt_next_s = cnt_r + 1'b1;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          cnt_next_s = {CW{1'b0}};
          if (stop_idx_r == STOP_LAST) begin
            done_next_s = 1'b1;
            if (!empty_s) begin
              pop_s        = 1'b1;
              shift_next_s = mem_r[rd_ptr_r];
              state_next_s = START;
            end else begin
              state_next_s = IDLE;
            end
          end else begin
            stop_idx_next_s = stop_idx_r + 1'b1;
          end
        end else begin
          cnt_next_s = cnt_r + 1'b1;
        end
      end
      default: begin
        cnt_next_s   = {CW{1'b0}};
        state_next_s = IDLE;
      end
    endcase
  end

  // Line level follows the state being entered so tx is a clean register output
  always_comb begin
    case (state_next_s)
      IDLE:    tx_next_s = 1'b1;
      START:   tx_next_s = 1'b0;
      DATA:    tx_next_s = shift_next_s[0];
      STOP:    tx_next_s = 1'b1;
      default: tx_next_s = 1'b1;
    endcase
  end

  // FSM registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= {CW{1'b0}};
      bit_idx_r  <= 3'd0;
      stop_idx_r <= 1'b0;
      shift_r    <= 8'h00;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      cnt_r      <= cnt_next_s;
      bit_idx_r  <= bit_idx_next_s;
      stop_idx_r <= stop_idx_next_s;
      shift_r    <= shift_next_s;
      tx_r       <= tx_next_s;
      busy_r     <= (state_r != IDLE) || !empty_s;
      done_r     <= done_next_s;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: default instance (DIV 104, 1 stop bit)
// and a second instance at 1 Mbaud with 2 stop bits (DIV 12).
module tb_uart_tx_fifo;
  localparam int DIV1  = 104;
  localparam int DIV2  = 12;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid, tx_valid2;
  logic [7:0] tx_data, tx_data2;
  logic       tx_ready, tx, tx_busy, tx_done;
  logic       tx_ready2, tx2, tx_busy2, tx_done2;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         done_cnt = 0;
  int         last_done_cyc = 0;
  int         done2_q[$];
  logic [7:0] exp_q[$];

  uart_tx_fifo u_dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  uart_tx_fifo #(.clk_freq(12000000), .baud(1000000), .fifo_depth(4), .stop_bits(2)) u_dut2 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid2), .tx_data(tx_data2),
    .tx_ready(tx_ready2), .tx(tx2), .tx_busy(tx_busy2), .tx_done(tx_done2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_done === 1'b1) begin
      done_cnt      <= done_cnt + 1;
      last_done_cyc <= cyc;
    end
    if (tx_done2 === 1'b1) done2_q.push_back(cyc);
  end

  function automatic logic line_of(input bit sel);
    return sel ? tx2 : tx;
  endfunction

  task automatic wait_fall(input bit sel, input int budget, output int t, output bit timed_out);
    timed_out = 1'b1;
    t = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (line_of(sel) === 1'b0) begin
        t = cyc;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  // Compares every clock of one frame against the ideal start/data/stop waveform.
  task automatic read_frame(input bit sel, input int div, input int nstop, input bit have_first,
                            input logic [7:0] exp, output int errs);
    logic lvl;
    errs = 0;
    for (int b = 0; b < 9 + nstop; b++) begin
      if (b == 0) lvl = 1'b0;
      else if (b <= 8) lvl = exp[b-1];
      else lvl = 1'b1;
      for (int k = 0; k < div; k++) begin
        if (!(b == 0 && k == 0 && have_first)) @(negedge clk);
        if (line_of(sel) !== lvl) errs++;
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    tx_valid = 1'b0; tx_valid2 = 1'b0;
    tx_data = 8'($urandom); tx_data2 = 8'($urandom);
    repeat (5) @(negedge clk);
    n_checks++; if ({tx, tx_busy, tx_ready, tx_done} !== 4'b1010) begin n_fail++;
      $display("FAIL reset_hold: tx/busy/ready/done=%b required 1010", {tx, tx_busy, tx_ready, tx_done}); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if ({tx, tx_busy, tx_ready, tx_done} !== 4'b1010) begin n_fail++;
      $display("FAIL reset_release: tx/busy/ready/done=%b required 1010", {tx, tx_busy, tx_ready, tx_done}); end
    bad = 0;
    repeat (2000) begin
      @(negedge clk);
      tx_data = 8'($urandom);
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++;
      $display("FAIL reset_idle_2000: %0d non-idle cycles, required 0", bad); end
  endtask

  task automatic test_single_byte();
    int e0, t, errs, base;
    bit to;
    base = done_cnt;
    tx_valid = 1'b1; tx_data = 8'h55;
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++;
      $display("FAIL single_ready: tx_ready=%b required 1", tx_ready); end
    @(negedge clk);
    e0 = cyc;
    tx_valid = 1'b0; tx_data = 8'($urandom);
    n_checks++; if ({tx, tx_busy} !== 2'b10) begin n_fail++;
      $display("FAIL single_after_accept: tx/busy=%b required 10", {tx, tx_busy}); end
    wait_fall(1'b0, 10, t, to);
    n_checks++; if (to || t != e0 + 1) begin n_fail++;
      $display("FAIL single_latency: fall at %0d (timeout %0d), required %0d", t, to, e0 + 1); end
    if (!to) begin
      n_checks++; if (tx_busy !== 1'b1) begin n_fail++;
        $display("FAIL single_busy_rise: tx_busy=%b required 1", tx_busy); end
      read_frame(1'b0, DIV1, 1, 1'b1, 8'h55, errs);
      n_checks++; if (errs != 0) begin n_fail++;
        $display("FAIL single_frame: %0d wrong samples, required 0", errs); end
      @(negedge clk);
      n_checks++; if ({tx, tx_done, tx_busy} !== 3'b111) begin n_fail++;
        $display("FAIL single_done: tx/done/busy=%b required 111", {tx, tx_done, tx_busy}); end
      @(negedge clk);
      n_checks++; if ({tx_done, tx_busy} !== 2'b00) begin n_fail++;
        $display("FAIL single_busy_fall: done/busy=%b required 00", {tx_done, tx_busy}); end
      @(negedge clk);
      n_checks++; if (done_cnt - base != 1 || last_done_cyc - t != 10 * DIV1) begin n_fail++;
        $display("FAIL single_done_timing: pulses=%0d offset=%0d required 1 and %0d",
                 done_cnt - base, last_done_cyc - t, 10 * DIV1); end
    end
  endtask

  task automatic test_burst();
    int base, t0, errs, nxt, accepts, drop_at, guard;
    bit to;
    logic [7:0] e;
    base = done_cnt;
    exp_q.delete();
    fork
      begin
        nxt = 1; accepts = 0; drop_at = -1; guard = 0;
        while (nxt <= 6 && guard < 5000) begin
          tx_valid = 1'b1; tx_data = 8'(nxt);
          if (tx_ready === 1'b1) begin
            exp_q.push_back(8'(nxt));
            nxt++; accepts++;
          end else if (drop_at < 0) begin
            drop_at = accepts;
          end
          @(negedge clk);
          guard++;
        end
        tx_valid = 1'b0;
      end
      begin
        wait_fall(1'b0, 20, t0, to);
        n_checks++; if (to) begin n_fail++;
          $display("FAIL burst_start: no start bit, required within 20 clocks"); end
        for (int f = 0; f < 6 && !to; f++) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
          read_frame(1'b0, DIV1, 1, (f == 0), e, errs);
          n_checks++; if (errs != 0) begin n_fail++;
            $display("FAIL burst_frame%0d: %0d wrong samples for byte %h, required 0", f, errs, 8'(f + 1)); end
        end
        if (!to) begin
          @(negedge clk);
          n_checks++; if (tx !== 1'b1) begin n_fail++;
            $display("FAIL burst_idle: tx=%b required 1", tx); end
          @(negedge clk);
          n_checks++; if (done_cnt - base != 6 || last_done_cyc - t0 != 60 * DIV1) begin n_fail++;
            $display("FAIL burst_length: pulses=%0d span=%0d required 6 and %0d",
                     done_cnt - base, last_done_cyc - t0, 60 * DIV1); end
        end
      end
    join
    n_checks++; if (drop_at != DEPTH + 1 || nxt != 7) begin n_fail++;
      $display("FAIL burst_ready_drop: dropped after %0d accepts (next %0d), required %0d", drop_at, nxt, DEPTH + 1); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] b[5];
    logic [7:0] e;
    int e0, t, errs, bad;
    bit to;
    for (int i = 0; i < 5; i++) b[i] = 8'($urandom);
    exp_q.delete();
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          tx_valid = 1'b1; tx_data = b[i];
          n_checks++; if (tx_ready !== 1'b1) begin n_fail++;
            $display("FAIL full_fill%0d: tx_ready=%b required 1", i, tx_ready); end
          exp_q.push_back(b[i]);
          @(negedge clk);
          if (i == 0) e0 = cyc;
        end
        tx_valid = 1'b0; tx_data = 8'($urandom);
        while (cyc < e0 + 10 * DIV1) @(negedge clk);
        tx_valid = 1'b1; tx_data = 8'($urandom);
        n_checks++; if (tx_ready !== 1'b0) begin n_fail++;
          $display("FAIL full_ready_low: tx_ready=%b required 0", tx_ready); end
        @(negedge clk);
        tx_valid = 1'b0;
        n_checks++; if ({tx_ready, tx_done} !== 2'b11) begin n_fail++;
          $display("FAIL full_pop_edge: ready/done=%b required 11", {tx_ready, tx_done}); end
      end
      begin
        wait_fall(1'b0, 20, t, to);
        n_checks++; if (to) begin n_fail++;
          $display("FAIL full_start: no start bit, required within 20 clocks"); end
        for (int f = 0; f < 5 && !to; f++) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
          read_frame(1'b0, DIV1, 1, (f == 0), e, errs);
          n_checks++; if (errs != 0) begin n_fail++;
            $display("FAIL full_frame%0d: %0d wrong samples, required 0", f, errs); end
        end
        bad = 0;
        repeat (2 * 10 * DIV1 + 5) begin
          @(negedge clk);
          if (tx !== 1'b1) bad++;
        end
        n_checks++; if (bad != 0 || tx_busy !== 1'b0) begin n_fail++;
          $display("FAIL full_no_extra: %0d low samples busy=%b, required 0 and 0", bad, tx_busy); end
      end
    join
  endtask

  task automatic test_reset_mid_frame();
    int e0, bad, base;
    base = done_cnt;
    tx_valid = 1'b1; tx_data = 8'hA3;
    @(negedge clk);
    e0 = cyc;
    tx_data = 8'($urandom);
    @(negedge clk);
    tx_data = 8'($urandom);
    @(negedge clk);
    tx_valid = 1'b0;
    while (cyc < e0 + 1 + 4 * DIV1 + 50) @(negedge clk);
    n_checks++; if ({tx, tx_busy} !== 2'b01) begin n_fail++;
      $display("FAIL midrst_bit3: tx/busy=%b required 01", {tx, tx_busy}); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({tx, tx_ready} !== 2'b11) begin n_fail++;
      $display("FAIL midrst_async: tx/ready=%b required 11", {tx, tx_ready}); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (2500) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0 || tx_ready !== 1'b1 || done_cnt != base) begin n_fail++;
      $display("FAIL midrst_after: %0d bad cycles ready=%b pulses=%0d, required 0, 1, 0",
               bad, tx_ready, done_cnt - base); end
  endtask

  task automatic test_two_stop();
    int e0, t, errs;
    bit to;
    done2_q.delete();
    fork
      begin
        tx_valid2 = 1'b1; tx_data2 = 8'hFF;
        n_checks++; if (tx_ready2 !== 1'b1) begin n_fail++;
          $display("FAIL stop2_ready: tx_ready=%b required 1", tx_ready2); end
        @(negedge clk);
        e0 = cyc;
        tx_data2 = 8'h00;
        @(negedge clk);
        tx_valid2 = 1'b0;
      end
      begin
        wait_fall(1'b1, 20, t, to);
        n_checks++; if (to || t != e0 + 1) begin n_fail++;
          $display("FAIL stop2_latency: fall at %0d (timeout %0d), required %0d", t, to, e0 + 1); end
        if (!to) begin
          read_frame(1'b1, DIV2, 2, 1'b1, 8'hFF, errs);
          n_checks++; if (errs != 0) begin n_fail++;
            $display("FAIL stop2_frame0: %0d wrong samples, required 0", errs); end
          read_frame(1'b1, DIV2, 2, 1'b0, 8'h00, errs);
          n_checks++; if (errs != 0) begin n_fail++;
            $display("FAIL stop2_frame1: %0d wrong samples, required 0", errs); end
          repeat (3) @(negedge clk);
          n_checks++; if (done2_q.size() != 2) begin n_fail++;
            $display("FAIL stop2_done_count: %0d pulses, required 2", done2_q.size()); end
          else begin
            n_checks++; if (done2_q[0] - t != 11 * DIV2 || done2_q[1] - t != 22 * DIV2) begin n_fail++;
              $display("FAIL stop2_done_timing: offsets %0d,%0d required %0d,%0d",
                       done2_q[0] - t, done2_q[1] - t, 11 * DIV2, 22 * DIV2); end
          end
          n_checks++; if ({tx2, tx_busy2} !== 2'b10) begin n_fail++;
            $display("FAIL stop2_idle: tx/busy=%b required 10", {tx2, tx_busy2}); end
        end
      end
    join
  endtask

  task automatic test_random();
    int t, errs, g;
    bit to;
    logic [7:0] d, e;
    exp_q.delete();
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          repeat ($urandom_range(0, 300)) begin
            @(negedge clk);
            tx_data = 8'($urandom);
          end
          d = 8'($urandom);
          tx_valid = 1'b1; tx_data = d;
          g = 0;
          while (tx_ready !== 1'b1 && g < 3000) begin
            @(negedge clk);
            g++;
          end
          exp_q.push_back(d);
          @(negedge clk);
          tx_valid = 1'b0;
        end
      end
      begin
        for (int i = 0; i < 8; i++) begin
          wait_fall(1'b0, 4000, t, to);
          n_checks++; if (to || exp_q.size() == 0) begin n_fail++;
            $display("FAIL rand_start%0d: timeout=%0d queued=%0d, required a start bit", i, to, exp_q.size()); break; end
          e = exp_q.pop_front();
          read_frame(1'b0, DIV1, 1, 1'b1, e, errs);
          n_checks++; if (errs != 0) begin n_fail++;
            $display("FAIL rand_frame%0d: %0d wrong samples for byte %h, required 0", i, errs, e); end
        end
      end
    join
    g = 0;
    while (tx_busy !== 1'b0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    n_checks++; if (tx_busy !== 1'b0 || exp_q.size() != 0) begin n_fail++;
      $display("FAIL rand_drain: busy=%b leftover=%0d, required 0 and 0", tx_busy, exp_q.size()); end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_byte();
    test_burst();
    test_full_push_pop();
    test_reset_mid_frame();
    test_two_stop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
